ice_rx_frame_buffer: RTL and testbench

Circular frame store between the host-side byte receiver (UART/USB RX) and the frame consumers (header decoder and downstream parsers). Accepts a byte stream with end-of-frame and abort markers. Stores each byte as a 9-bit word {eof, data}. Exposes committed frames through a random-access read port anchored at a tail pointer that the consumer advances on release.

---
 rtl/ice_rx_frame_buffer_pkg.sv | 8 +
 rtl/ice_frame_ram.sv | 18 +
 rtl/ice_rx_frame_buffer.sv | 87 ++++++++
 tb/tb_ice_rx_frame_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ice_rx_frame_buffer_pkg.sv
// ice_rx_frame_buffer_pkg: word layout and default sizing shared by the RX frame buffer
package ice_rx_frame_buffer_pkg;
  localparam int EOF_BIT = 8;
  localparam int DATA_MSB = 7;
  localparam int WORD_W = EOF_BIT + 1;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_CNT_W = 9;
endpackage

// File: rtl/ice_frame_ram.sv
// ice_frame_ram: simple dual-port RAM with registered read, swappable for a vendor macro
module ice_frame_ram
  import ice_rx_frame_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  always_ff @(posedge clk) o_rdata <= rst ? '0 : r_mem[i_raddr];
endmodule

// File: rtl/ice_rx_frame_buffer.sv
// ice_rx_frame_buffer: circular {eof,data} frame store with commit/abort/drop and tail-anchored reads
module ice_rx_frame_buffer
  import ice_rx_frame_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_MSB:0] i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_rx_eof,
  input  logic              i_rx_abort,
  output logic              o_overflow,
  input  logic              i_overflow_clear,
  output logic              o_frame_valid,
  output logic [ADDR_W-1:0] o_frame_tail,
  output logic [CNT_W-1:0]  o_frame_count,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_rd_data_valid,
  input  logic              i_release,
  input  logic [ADDR_W-1:0] i_release_addr
);
  logic [ADDR_W-1:0] r_head, r_commit, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_dropping, r_overflow, r_fv, r_rd_valid;
  logic [ADDR_W-1:0] w_head_inc, w_rd_off, w_used;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_full, w_wr, w_we, w_commit, w_rel;
  always_comb begin
    w_head_inc = r_head + ADDR_W'(1);
    w_full = w_head_inc == r_tail;
    w_wr = i_rx_valid & ~i_rx_abort & ~r_dropping;
    w_we = w_wr & ~w_full;
    w_commit = w_we & i_rx_eof;
    w_rel = i_release & (r_count != '0);
    w_cnt_nxt = r_count + CNT_W'(w_commit) - CNT_W'(w_rel);
    w_rd_off = i_rd_addr - r_tail;
    w_used = r_commit - r_tail;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_commit <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_dropping <= 1'b0;
      r_overflow <= 1'b0;
      r_fv <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      // a release always shows the consumer one idle cycle as a frame boundary
      r_fv <= ~w_rel & (w_cnt_nxt != '0);
      r_rd_valid <= r_fv & (w_rd_off < w_used);
      r_overflow <= (w_wr & w_full) | (r_overflow & ~i_overflow_clear);
      if (w_rel) r_tail <= i_release_addr;
      if (i_rx_abort) begin
        r_head <= r_commit;
        r_dropping <= 1'b0;
      end else if (i_rx_valid & r_dropping) begin
        r_dropping <= ~i_rx_eof;
      end else if (w_we) begin
        r_head <= w_head_inc;
        if (i_rx_eof) r_commit <= w_head_inc;
      end else if (w_wr) begin
        r_head <= r_commit;
        r_dropping <= ~i_rx_eof;
      end
    end
  end
  ice_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .rst(rst),
    .i_we(w_we),
    .i_waddr(r_head),
    .i_wdata({i_rx_eof, i_rx_data}),
    .i_raddr(i_rd_addr),
    .o_rdata(o_rd_data)
  );
  assign o_overflow = r_overflow;
  assign o_frame_valid = r_fv;
  assign o_frame_tail = r_tail;
  assign o_frame_count = r_count;
  assign o_rd_data_valid = r_rd_valid;
endmodule

// File: tb/tb_ice_rx_frame_buffer.sv
// tb_ice_rx_frame_buffer: directed scenario tests of the RX frame buffer on a 16-word instance
module tb_ice_rx_frame_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, rx_eof = 1'b0, rx_abort = 1'b0, ov_clr = 1'b0, rel = 1'b0;
  logic [3:0] rel_addr = '0, rd_addr = '0;
  logic       overflow, fv, rd_valid;
  logic [3:0] tail;
  logic [8:0] count, rd_data;
  int checks = 0, errors = 0;
  ice_rx_frame_buffer #(.ADDR_W(4), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_eof(rx_eof),
    .i_rx_abort(rx_abort), .o_overflow(overflow), .i_overflow_clear(ov_clr),
    .o_frame_valid(fv), .o_frame_tail(tail), .o_frame_count(count), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_data_valid(rd_valid), .i_release(rel), .i_release_addr(rel_addr)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task send(input logic [7:0] d, input logic e);
    rx_data = d; rx_valid = 1'b1; rx_eof = e;
    tick();
    rx_valid = 1'b0; rx_eof = 1'b0;
  endtask
  task release_to(input logic [3:0] a);
    rel = 1'b1; rel_addr = a;
    tick();
    rel = 1'b0;
  endtask
  task rd(input logic [3:0] a);
    rd_addr = a;
    tick();
  endtask
  task do_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask
  task test_reset;
    do_reset();
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", fv); end
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (tail !== 4'd0) begin errors++; $display("FAIL reset_tail: got %0d expected 0", tail); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (rd_data !== 9'h000 || rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd: got %h/%b expected 000/0", rd_data, rd_valid); end
  endtask
  task test_single_frame;
    do_reset();
    send(8'h05, 0); send(8'hA1, 0);
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL sf_fv_early: got %b expected 0", fv); end
    rd(0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sf_uncommitted: got %b expected 0", rd_valid); end
    send(8'h00, 1);
    checks++; if (fv !== 1'b1 || count !== 9'd1) begin errors++; $display("FAIL sf_commit: got fv=%b cnt=%0d expected 1/1", fv, count); end
    rd(0);
    checks++; if (rd_data !== 9'h005 || rd_valid !== 1'b1) begin errors++; $display("FAIL sf_rd0: got %h/%b expected 005/1", rd_data, rd_valid); end
    rd(1);
    checks++; if (rd_data !== 9'h0A1 || rd_valid !== 1'b1) begin errors++; $display("FAIL sf_rd1: got %h/%b expected 0a1/1", rd_data, rd_valid); end
    rd(2);
    checks++; if (rd_data !== 9'h100 || rd_valid !== 1'b1) begin errors++; $display("FAIL sf_rd2: got %h/%b expected 100/1", rd_data, rd_valid); end
    rd(3);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL sf_rd3: got %b expected 0", rd_valid); end
  endtask
  task test_release;
    do_reset();
    send(8'h11, 0); send(8'h12, 1);
    send(8'h21, 0); send(8'h22, 0); send(8'h23, 0); send(8'h24, 1);
    checks++; if (count !== 9'd2) begin errors++; $display("FAIL rel_count2: got %0d expected 2", count); end
    release_to(2);
    checks++; if (tail !== 4'd2 || count !== 9'd1 || fv !== 1'b0) begin errors++; $display("FAIL rel_after: got tail=%0d cnt=%0d fv=%b expected 2/1/0", tail, count, fv); end
    rd(1);
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL rel_fv_back: got %b expected 1", fv); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rel_rd_low: got %b expected 0", rd_valid); end
    rd(1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rel_old_word: got %b expected 0", rd_valid); end
    rd(2);
    checks++; if (rd_data !== 9'h021 || rd_valid !== 1'b1) begin errors++; $display("FAIL rel_rd2: got %h/%b expected 021/1", rd_data, rd_valid); end
    rd(5);
    checks++; if (rd_data !== 9'h124 || rd_valid !== 1'b1) begin errors++; $display("FAIL rel_rd5: got %h/%b expected 124/1", rd_data, rd_valid); end
  endtask
  task test_abort;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), 0);
    rx_abort = 1'b1; tick(); rx_abort = 1'b0;
    rx_abort = 1'b1; rx_valid = 1'b1; rx_eof = 1'b1; rx_data = 8'h99; tick();
    rx_abort = 1'b0; rx_valid = 1'b0; rx_eof = 1'b0;
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL ab_count0: got %0d expected 0", count); end
    send(8'h33, 0); send(8'h34, 1);
    checks++; if (count !== 9'd1) begin errors++; $display("FAIL ab_count1: got %0d expected 1", count); end
    rd(0);
    checks++; if (rd_data !== 9'h033 || rd_valid !== 1'b1) begin errors++; $display("FAIL ab_rd0: got %h/%b expected 033/1", rd_data, rd_valid); end
    rd(1);
    checks++; if (rd_data !== 9'h134 || rd_valid !== 1'b1) begin errors++; $display("FAIL ab_rd1: got %h/%b expected 134/1", rd_data, rd_valid); end
    rd(2);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ab_rd2: got %b expected 0", rd_valid); end
  endtask
  task test_overflow;
    do_reset();
    for (int i = 0; i < 15; i++) send(8'h60 + 8'(i), i == 14);
    checks++; if (count !== 9'd1 || overflow !== 1'b0) begin errors++; $display("FAIL ov_full: got cnt=%0d ov=%b expected 1/0", count, overflow); end
    ov_clr = 1'b1; send(8'h70, 0); ov_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ov_set_wins: got %b expected 1", overflow); end
    send(8'h71, 0); send(8'h72, 1);
    checks++; if (count !== 9'd1 || overflow !== 1'b1) begin errors++; $display("FAIL ov_drop: got cnt=%0d ov=%b expected 1/1", count, overflow); end
    rd(14);
    checks++; if (rd_data !== 9'h16E || rd_valid !== 1'b1) begin errors++; $display("FAIL ov_rd14: got %h/%b expected 16e/1", rd_data, rd_valid); end
    rd(15);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ov_rd15: got %b expected 0", rd_valid); end
    release_to(15);
    checks++; if (count !== 9'd0) begin errors++; $display("FAIL ov_rel: got %0d expected 0", count); end
    send(8'h80, 0); send(8'h81, 1);
    rd(15);
    checks++; if (rd_data !== 9'h080 || rd_valid !== 1'b1) begin errors++; $display("FAIL ov_head_kept: got %h/%b expected 080/1", rd_data, rd_valid); end
    rd(0);
    checks++; if (rd_data !== 9'h181 || rd_valid !== 1'b1) begin errors++; $display("FAIL ov_rd0: got %h/%b expected 181/1", rd_data, rd_valid); end
    ov_clr = 1'b1; tick(); ov_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ov_clear: got %b expected 0", overflow); end
  endtask
  task test_wrap;
    logic [8:0] exp [5];
    exp = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h145};
    do_reset();
    for (int i = 0; i < 14; i++) send(8'h30 + 8'(i), i == 13);
    release_to(14);
    for (int i = 0; i < 5; i++) send(8'h41 + 8'(i), i == 4);
    checks++; if (count !== 9'd1 || tail !== 4'd14) begin errors++; $display("FAIL wr_state: got cnt=%0d tail=%0d expected 1/14", count, tail); end
    for (int i = 0; i < 5; i++) begin
      rd(4'(14 + i));
      checks++; if (rd_data !== exp[i] || rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd%0d: got %h/%b expected %h/1", i, rd_data, rd_valid, exp[i]); end
    end
    rd(3);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wr_rd3: got %b expected 0", rd_valid); end
    release_to(3);
    checks++; if (count !== 9'd0 || tail !== 4'd3 || fv !== 1'b0) begin errors++; $display("FAIL wr_rel: got cnt=%0d tail=%0d fv=%b expected 0/3/0", count, tail, fv); end
    tick();
    checks++; if (fv !== 1'b0) begin errors++; $display("FAIL wr_fv_stays: got %b expected 0", fv); end
  endtask
  task test_back_to_back;
    do_reset();
    send(8'h01, 0); send(8'h02, 1);
    send(8'h51, 0);
    rel = 1'b1; rel_addr = 4'd2;
    send(8'h52, 1);
    rel = 1'b0;
    checks++; if (count !== 9'd1 || tail !== 4'd2 || fv !== 1'b0) begin errors++; $display("FAIL bb_same: got cnt=%0d tail=%0d fv=%b expected 1/2/0", count, tail, fv); end
    rd(2);
    checks++; if (fv !== 1'b1) begin errors++; $display("FAIL bb_fv_back: got %b expected 1", fv); end
    rd(2);
    checks++; if (rd_data !== 9'h051 || rd_valid !== 1'b1) begin errors++; $display("FAIL bb_rd2: got %h/%b expected 051/1", rd_data, rd_valid); end
    rd(3);
    checks++; if (rd_data !== 9'h152 || rd_valid !== 1'b1) begin errors++; $display("FAIL bb_rd3: got %h/%b expected 152/1", rd_data, rd_valid); end
    rd(4);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bb_rd4: got %b expected 0", rd_valid); end
    rd_addr = 4'd3;
    send(8'h60, 0); send(8'h61, 0);
    rst = 1'b1; tick();
    checks++; if (count !== 9'd0 || tail !== 4'd0 || fv !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL bb_rst_state: got cnt=%0d tail=%0d fv=%b ov=%b expected 0/0/0/0", count, tail, fv, overflow); end
    checks++; if (rd_data !== 9'h000 || rd_valid !== 1'b0) begin errors++; $display("FAIL bb_rst_rd: got %h/%b expected 000/0", rd_data, rd_valid); end
    rst = 1'b0;
    send(8'h77, 1);
    rd(0);
    checks++; if (rd_data !== 9'h177 || rd_valid !== 1'b1) begin errors++; $display("FAIL bb_post_rst: got %h/%b expected 177/1", rd_data, rd_valid); end
    rd(1);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL bb_post_rst1: got %b expected 0", rd_valid); end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_release();
    test_abort();
    test_overflow();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
